// File: rtl/uart_xmit_queue.sv
`default_nettype none
// ============================================================================
// uart_xmit_queue : byte FIFO driving the UART transmitter xmitH/xmit_dataH
// request. Macro UART_XQ_GAP_EN adds an inter-frame idle gap.   Rev 1.0
// ============================================================================
module uart_xmit_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int GAP_CYCLES  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  input  logic              ovf_clr,
  output logic              ovfH,
  output logic              toH,
  output logic              xmitH,
  output logic [7:0]        xmit_dataH,
  input  logic              xmit_doneH
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
`ifdef UART_XQ_GAP_EN
  localparam logic [1:0] ST_GAP  = 2'd3;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
`endif

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_nxt;
  logic [7:0]        head;
  logic              push;
  logic              can_send;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic              launch;
  logic              ack;
  logic              timeout;

  // A full FIFO is judged before any same-cycle pop, so a write into a
  // full queue is dropped even if a byte leaves in that cycle.
  assign push     = wr_en && !full;
  assign head     = mem[rd_ptr];
  assign can_send = !empty && xmit_doneH;

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    count_nxt = count;
    if (push && !launch) begin
      count_nxt = count + CNT_ONE;
    end else if (!push && launch) begin
      count_nxt = count - CNT_ONE;
    end
  end

`ifdef UART_XQ_GAP_EN
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_last;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      gap_cnt <= '0;
    end else if (state != ST_GAP) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GAP_ONE;
    end
  end

  assign gap_last = (gap_cnt == GAP_LAST);
`endif

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (launch) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (ack) begin
          state_nxt = ST_BUSY;
        end else if (timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (xmit_doneH) begin
`ifdef UART_XQ_GAP_EN
          state_nxt = ST_GAP;
`else
          state_nxt = launch ? ST_REQ : ST_IDLE;
`endif
        end
      end
`ifdef UART_XQ_GAP_EN
      ST_GAP: begin
        if (gap_last) state_nxt = launch ? ST_REQ : ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: a launch pops the head byte into the request register.
  always_comb begin
    launch  = 1'b0;
    ack     = 1'b0;
    timeout = 1'b0;
    case (state)
      ST_IDLE: launch = can_send;
      ST_REQ: begin
        ack     = !xmit_doneH;
        timeout = xmit_doneH && (to_cnt == TO_LAST);
      end
`ifdef UART_XQ_GAP_EN
      ST_GAP:  launch = can_send && gap_last;
`else
      ST_BUSY: launch = can_send;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      ovfH       <= 1'b0;
      toH        <= 1'b0;
      xmitH      <= 1'b0;
      xmit_dataH <= 8'h00;
      to_cnt     <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (launch) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);

      if (wr_en && full) begin
        ovfH <= 1'b1;
      end else if (ovf_clr) begin
        ovfH <= 1'b0;
      end

      if (timeout) begin
        toH <= 1'b1;
      end else if (ovf_clr) begin
        toH <= 1'b0;
      end

      // Held only through a live request; any other state forces it low.
      xmitH <= launch || (state == ST_REQ && !ack && !timeout);
      if (launch) xmit_dataH <= head;

      if (launch) begin
        to_cnt <= '0;
      end else if (state == ST_REQ) begin
        to_cnt <= to_cnt + TO_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_xmit_queue.sv
`default_nettype none
// tb_uart_xmit_queue : scenario tasks with a transmitter model and a byte-order
// scoreboard for uart_xmit_queue.
module tb_uart_xmit_queue;
  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 64;
  localparam int GAP_CYCLES  = 16;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_l = 1'b0;
  logic              wr_en     = 1'b0;
  logic [7:0]        wr_data   = 8'h00;
  logic              ovf_clr   = 1'b0;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ovfH;
  logic              toH;
  logic              xmitH;
  logic [7:0]        xmit_dataH;
  logic              xmit_doneH;

  logic              man_done   = 1'b1;
  logic              model_en   = 1'b0;
  logic              model_done = 1'b1;
  int                busy_cnt   = 0;
  int                frame_len  = 160;
  logic [7:0]        got[$];

  int checks = 0;
  int errors = 0;

  assign xmit_doneH = model_en ? model_done : man_done;

  always #5 sys_clk = ~sys_clk;

  uart_xmit_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .ovf_clr(ovf_clr), .ovfH(ovfH),
    .toH(toH), .xmitH(xmitH), .xmit_dataH(xmit_dataH), .xmit_doneH(xmit_doneH)
  );

  // Transmitter model: accepts a request while idle, then stays busy frame_len cycles.
  always @(posedge sys_clk) begin
    if (!model_en) begin
      model_done <= 1'b1;
      busy_cnt   <= 0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_done <= 1'b1;
    end else if (xmitH && model_done) begin
      got.push_back(xmit_dataH);
      model_done <= 1'b0;
      busy_cnt   <= frame_len;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge sys_clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_rise(input int budget);
    int n;
    n = 0;
    while (!xmitH && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic test_reset;
    @(negedge sys_clk);
    checks++;
    if ({full, empty, ovfH, toH, xmitH} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 01000", {full, empty, ovfH, toH, xmitH});
    end
    checks++;
    if (count !== '0 || xmit_dataH !== 8'h00) begin
      errors++;
      $display("FAIL reset_count_data: got count=%0d data=%h expected 0/00", count, xmit_dataH);
    end
    sys_rst_l = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (empty !== 1'b1 || xmitH !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got empty=%b xmitH=%b expected 1/0", empty, xmitH);
    end
  endtask

  task automatic test_single;
    man_done = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA5;       // cycle N
    @(negedge sys_clk); wr_en = 1'b0;    // N+1
    @(negedge sys_clk);                  // N+2
    checks++;
    if (xmitH !== 1'b1 || xmit_dataH !== 8'hA5) begin
      errors++;
      $display("FAIL single_latency: got xmitH=%b data=%h expected 1/a5", xmitH, xmit_dataH);
    end
    @(negedge sys_clk);                  // N+3
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL single_empty: got %b expected 1", empty);
    end
    @(negedge sys_clk);                  // N+4
    checks++;
    if (xmitH !== 1'b1 || xmit_dataH !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold: got xmitH=%b data=%h expected 1/a5", xmitH, xmit_dataH);
    end
    man_done = 1'b0;
    @(negedge sys_clk);                  // N+5
    checks++;
    if (xmitH !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_drop: got %b expected 0", xmitH);
    end
    repeat (3) @(negedge sys_clk);
    man_done = 1'b1;
    repeat (30) @(negedge sys_clk);
  endtask

  task automatic test_fill_overflow;
    int k;
    man_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(8'(i + 1));
      checks++;
      if (count !== (ADDR_W + 1)'(i + 1)) begin
        errors++;
        $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1);
      end
    end
    checks++;
    if (full !== 1'b1 || ovfH !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got full=%b ovfH=%b expected 1/0", full, ovfH);
    end
    push_byte(8'h55);
    checks++;
    if (ovfH !== 1'b1 || count !== (ADDR_W + 1)'(DEPTH)) begin
      errors++;
      $display("FAIL overflow: got ovfH=%b count=%0d expected 1/%0d", ovfH, count, DEPTH);
    end
    wr_en = 1'b1; wr_data = 8'h66; ovf_clr = 1'b1;
    @(negedge sys_clk);
    wr_en = 1'b0; ovf_clr = 1'b0;
    checks++;
    if (ovfH !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: got %b expected 1", ovfH);
    end
    ovf_clr = 1'b1;
    @(negedge sys_clk);
    ovf_clr = 1'b0;
    checks++;
    if (ovfH !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", ovfH);
    end
    got.delete();
    frame_len = 3;
    model_en  = 1'b1;
    k = 0;
    while (got.size() < DEPTH && k < 1500) begin
      @(negedge sys_clk);
      k++;
    end
    repeat (45) @(negedge sys_clk);
    checks++;
    if (got.size() != DEPTH || empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_size: got %0d bytes empty=%b expected %0d/1", got.size(), empty, DEPTH);
    end
    for (int i = 0; i < DEPTH && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL drain_byte[%0d]: got %h expected %h", i, got[i], 8'(i + 1));
      end
    end
    model_en = 1'b0;
    man_done = 1'b1;
  endtask

  task automatic test_three_frames;
    logic [7:0] exp_b[3];
    logic [7:0] reqs[$];
    logic [7:0] held;
    logic       prev;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    man_done = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(exp_b[i]);
    got.delete();
    frame_len = 160;
    model_en  = 1'b1;
    prev = 1'b0;
    held = 8'h00;
    for (int c = 0; c < 800; c++) begin
      @(negedge sys_clk);
      if (xmitH && !prev) begin
        reqs.push_back(xmit_dataH);
        held = xmit_dataH;
      end else if (xmitH) begin
        checks++;
        if (xmit_dataH !== held) begin
          errors++;
          $display("FAIL data_stable: got %h expected %h", xmit_dataH, held);
        end
      end
      prev = xmitH;
    end
    checks++;
    if (reqs.size() != 3) begin
      errors++;
      $display("FAIL three_req_count: got %0d expected 3", reqs.size());
    end
    for (int i = 0; i < 3 && i < reqs.size(); i++) begin
      checks++;
      if (reqs[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL three_order[%0d]: got %h expected %h", i, reqs[i], exp_b[i]);
      end
    end
    model_en = 1'b0;
    man_done = 1'b1;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_timeout;
    logic [7:0] b1, b2;
    int hi;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    man_done = 1'b0;
    push_byte(b1);
    push_byte(b2);
    man_done = 1'b1;
    wait_rise(10);
    checks++;
    if (xmitH !== 1'b1 || xmit_dataH !== b1) begin
      errors++;
      $display("FAIL to_first_req: got xmitH=%b data=%h expected 1/%h", xmitH, xmit_dataH, b1);
    end
    hi = 0;
    while (xmitH && hi < 200) begin
      hi++;
      @(negedge sys_clk);
    end
    checks++;
    if (hi != ACK_TIMEOUT || toH !== 1'b1) begin
      errors++;
      $display("FAIL ack_timeout: got high=%0d toH=%b expected %0d/1", hi, toH, ACK_TIMEOUT);
    end
    wait_rise(5);
    checks++;
    if (xmitH !== 1'b1 || xmit_dataH !== b2) begin
      errors++;
      $display("FAIL to_next_req: got xmitH=%b data=%h expected 1/%h", xmitH, xmit_dataH, b2);
    end
    man_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    man_done = 1'b1;
    repeat (30) @(negedge sys_clk);
    ovf_clr = 1'b1;
    @(negedge sys_clk);
    ovf_clr = 1'b0;
    checks++;
    if (toH !== 1'b0 || xmitH !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: got toH=%b xmitH=%b expected 0/0", toH, xmitH);
    end
  endtask

  task automatic test_reset_mid_frame;
    int rises;
    man_done = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    checks++;
    if (count !== (ADDR_W + 1)'(6)) begin
      errors++;
      $display("FAIL mid_count6: got %0d expected 6", count);
    end
    man_done = 1'b1;
    wait_rise(5);
    man_done = 1'b0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (count !== (ADDR_W + 1)'(5) || xmitH !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: got count=%0d xmitH=%b expected 5/0", count, xmitH);
    end
    #2 sys_rst_l = 1'b0;
    #1;
    checks++;
    if (xmitH !== 1'b0 || count !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_async_reset: got xmitH=%b count=%0d empty=%b expected 0/0/1",
               xmitH, count, empty);
    end
    @(negedge sys_clk);
    sys_rst_l = 1'b1;
    man_done  = 1'b1;
    rises = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (xmitH) rises++;
    end
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL post_reset_no_req: got %0d request cycles expected 0", rises);
    end
    push_byte(8'h3C);
    wait_rise(5);
    #2 sys_rst_l = 1'b0;
    #1;
    checks++;
    if (xmitH !== 1'b0) begin
      errors++;
      $display("FAIL req_async_reset: got xmitH=%b expected 0", xmitH);
    end
    @(negedge sys_clk);
    sys_rst_l = 1'b1;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_gap_spacing;
    logic [7:0] b2;
    int n, exp_n;
`ifdef UART_XQ_GAP_EN
    exp_n = GAP_CYCLES + 1;
`else
    exp_n = 1;
`endif
    b2 = 8'($urandom);
    man_done = 1'b0;
    push_byte(8'($urandom));
    push_byte(b2);
    man_done = 1'b1;
    wait_rise(5);
    man_done = 1'b0;
    repeat (4) @(negedge sys_clk);
    man_done = 1'b1;
    n = 0;
    while (!xmitH && n < 60) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (n != exp_n || xmit_dataH !== b2) begin
      errors++;
      $display("FAIL gap_spacing: got %0d cycles data=%h expected %0d/%h", n, xmit_dataH, exp_n, b2);
    end
    man_done = 1'b0;
    repeat (2) @(negedge sys_clk);
    man_done = 1'b1;
    repeat (30) @(negedge sys_clk);
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    int nb, k;
    model_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      exp_q.delete();
      got.delete();
      frame_len = $urandom_range(2, 20);
      nb = $urandom_range(1, 10);
      for (int i = 0; i < nb; i++) begin
        exp_q.push_back(8'($urandom));
        push_byte(exp_q[i]);
        repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      end
      k = 0;
      while (got.size() < exp_q.size() && k < 3000) begin
        @(negedge sys_clk);
        k++;
      end
      repeat (45) @(negedge sys_clk);
      checks++;
      if (got.size() != exp_q.size() || ovfH !== 1'b0) begin
        errors++;
        $display("FAIL rand_size[%0d]: got %0d bytes ovfH=%b expected %0d/0",
                 r, got.size(), ovfH, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_byte[%0d][%0d]: got %h expected %h", r, i, got[i], exp_q[i]);
        end
      end
      checks++;
      if (empty !== 1'b1 || count !== '0) begin
        errors++;
        $display("FAIL rand_drained[%0d]: got empty=%b count=%0d expected 1/0", r, empty, count);
      end
    end
    model_en = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill_overflow;
    test_three_frames;
    test_timeout;
    test_reset_mid_frame;
    test_gap_spacing;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
